// File: rtl/gc_pkg.sv
// Shared types for the garbled-circuit gate issue path: sequencer states,
// free-gate truth tables and the gate descriptor carried to the garbling engine.
package gc_pkg;

  localparam int S = 20;

  localparam logic [3:0] LOGIC_XOR  = 4'b0110;
  localparam logic [3:0] LOGIC_XNOR = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_HDR,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  typedef struct packed {
    logic [S-1:0] in0;
    logic [S-1:0] in1;
    logic         in0f;
    logic         in1f;
    logic [3:0]   lgc;
    logic         is_output;
    logic [S-1:0] out_wire;
    logic [S-1:0] index;
    logic         free;
  } gate_desc_t;

  function automatic logic is_free_logic(input logic [3:0] lgc);
    return (lgc == LOGIC_XOR) || (lgc == LOGIC_XNOR);
  endfunction

endpackage

// File: rtl/gate_fifo.sv
// Two-entry descriptor buffer between the gate walker and the garbling engine.
// A push while full is taken only when a pop happens in the same cycle.
module gate_fifo
  import gc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  gate_desc_t din,
  output gate_desc_t dout,
  output logic       full,
  output logic       empty
);

  gate_desc_t mem [2];
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_pop;
  logic       do_push;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gate_issue.sv
// Gate-list sequencer: latches the netlist header, walks gate addresses and
// issues one descriptor per gate. Define FREE_XOR_EN to mark XOR/XNOR gates free.
module gate_issue
  import gc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                nl_done,
  input  logic signed [S-1:0] init_size,
  input  logic signed [S-1:0] input_size,
  input  logic signed [S-1:0] dff_size,
  input  logic signed [S-1:0] gate_size,
  output logic        [S-1:0] rd_addr,
  input  logic signed [S-1:0] in0,
  input  logic signed [S-1:0] in1,
  input  logic                in0F,
  input  logic                in1F,
  input  logic        [3:0]   g_logic,
  input  logic                is_output,
  output logic                g_valid,
  input  logic                g_ready,
  output logic        [S-1:0] g_in0,
  output logic        [S-1:0] g_in1,
  output logic        [S-1:0] g_out_wire,
  output logic        [S-1:0] g_index,
  output logic                g_in0F,
  output logic                g_in1F,
  output logic                g_is_output,
  output logic                g_free,
  output logic        [3:0]   g_logic_o,
  output logic                busy,
  output logic                done,
  output logic        [S-1:0] table_count
);

  state_t       state, state_nxt;
  logic [S-1:0] gate_size_q;
  logic [S-1:0] base_q;
  logic [S-1:0] last_addr;
  gate_desc_t   desc, head;
  logic         full, empty, push, pop, last, hdr_empty;

  assign pop       = g_valid && g_ready;
  assign push      = (state == ST_ISSUE) && (!full || pop);
  assign last_addr = gate_size_q - S'(1);
  assign last      = (rd_addr == last_addr);
  assign hdr_empty = gate_size[S-1] || (gate_size == '0);

  always_comb begin
    desc           = '0;
    desc.in0       = in0;
    desc.in1       = in1;
    desc.in0f      = in0F;
    desc.in1f      = in1F;
    desc.lgc       = g_logic;
    desc.is_output = is_output;
    desc.out_wire  = base_q + rd_addr;
    desc.index     = rd_addr;
`ifdef FREE_XOR_EN
    desc.free      = is_free_logic(g_logic);
`else
    desc.free      = 1'b0;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_WAIT_HDR;
      ST_WAIT_HDR: if (nl_done) state_nxt = hdr_empty ? ST_FINISH : ST_ISSUE;
      ST_ISSUE:    if (push && last) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (empty) state_nxt = ST_FINISH;
      ST_FINISH:   state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rd_addr     <= '0;
      table_count <= '0;
      gate_size_q <= '0;
      base_q      <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && start) table_count <= '0;
      if ((state == ST_WAIT_HDR) && nl_done) begin
        gate_size_q <= gate_size;
        base_q      <= init_size + input_size + dff_size;
        rd_addr     <= '0;
      end
      // rd_addr parks on the last gate once it has been pushed
      if (push) begin
        if (!last) rd_addr <= rd_addr + S'(1);
        if (!desc.free) table_count <= table_count + S'(1);
      end
    end
  end

  gate_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (desc),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign g_valid     = !empty;
  assign g_in0       = head.in0;
  assign g_in1       = head.in1;
  assign g_in0F      = head.in0f;
  assign g_in1F      = head.in1f;
  assign g_logic_o   = head.lgc;
  assign g_is_output = head.is_output;
  assign g_out_wire  = head.out_wire;
  assign g_index     = head.index;
  assign g_free      = head.free;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_FINISH);

endmodule
